// File: rtl/gb_bus_pkg.sv
// Shared types and address-map constants for the Game Boy cartridge bus frontend.
// Contents:
//   bus_state_t - FSM states of the bus-cycle tracker
//   ROM_END, RAM_BASE, RAM_END - cartridge address-map boundaries
//   in_rom / in_ram - address-window helpers
package gb_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    COMMIT = 3'd3,
    ERR    = 3'd4
  } bus_state_t;

  localparam logic [15:0] ROM_END  = 16'h7FFF;
  localparam logic [15:0] RAM_BASE = 16'hA000;
  localparam logic [15:0] RAM_END  = 16'hBFFF;

  function automatic logic in_rom(input logic [15:0] addr);
    return (addr <= ROM_END);
  endfunction

  function automatic logic in_ram(input logic [15:0] addr);
    return (addr >= RAM_BASE) && (addr <= RAM_END);
  endfunction

endpackage

// File: rtl/gb_bus_frontend_if.sv
// Bundle of raw cartridge-edge inputs and clean bus-event outputs.
// Signals:
//   gb_wr/gb_rd/gb_cs (active low), gb_addr[15:0], gb_data[7:0] - raw cartridge side
//   bus_addr, bus_wdata, wr_pulse, rom_rd, ram_rd, bus_err, glitch_cnt - clean side
// Modports: master drives the raw side (cartridge/bench), slave is the frontend.
interface gb_bus_frontend_if #(
  parameter int GLITCH_CNT_W = 8
);
  logic                    gb_wr;
  logic                    gb_rd;
  logic                    gb_cs;
  logic [15:0]             gb_addr;
  logic [7:0]              gb_data;
  logic [15:0]             bus_addr;
  logic [7:0]              bus_wdata;
  logic                    wr_pulse;
  logic                    rom_rd;
  logic                    ram_rd;
  logic                    bus_err;
  logic [GLITCH_CNT_W-1:0] glitch_cnt;

  modport master (
    output gb_wr, gb_rd, gb_cs, gb_addr, gb_data,
    input  bus_addr, bus_wdata, wr_pulse, rom_rd, ram_rd, bus_err, glitch_cnt
  );

  modport slave (
    input  gb_wr, gb_rd, gb_cs, gb_addr, gb_data,
    output bus_addr, bus_wdata, wr_pulse, rom_rd, ram_rd, bus_err, glitch_cnt
  );
endinterface

// File: rtl/gb_strobe_filter.sv
// One raw strobe bit: synchroniser followed by a consecutive-sample glitch filter.
// Ports:
//   clk, rst (async, active low)
//   raw    - asynchronous strobe input (idle high)
//   level  - filtered level (1 = deasserted)
//   glitch - one-clk strobe when a partial transition is abandoned
// The filter register doubles as the last synchroniser stage, so a new raw
// level counted for FILTER_CYCLES samples flips level at edge
// SYNC_STAGES + FILTER_CYCLES - 1.
module gb_strobe_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic glitch
);

  localparam logic [3:0] FLIP_AT = 4'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-2:0] sync_r;
  logic                   sample_s;
  logic                   level_r;
  logic                   glitch_r;
  logic [3:0]             cnt_r;

  // Synchroniser chain, preset idle-high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= {(SYNC_STAGES-1){1'b1}};
    end else begin
      sync_r[0] <= raw;
      for (int i = 1; i < SYNC_STAGES - 1; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign sample_s = sync_r[SYNC_STAGES-2];

  // Count consecutive differing samples; flip on the last, flag abandoned runs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_r  <= 1'b1;
      cnt_r    <= 4'd0;
      glitch_r <= 1'b0;
    end else if (sample_s != level_r) begin
      glitch_r <= 1'b0;
      if (cnt_r == FLIP_AT) begin
        level_r <= sample_s;
        cnt_r   <= 4'd0;
      end else begin
        cnt_r <= cnt_r + 4'd1;
      end
    end else begin
      glitch_r <= (cnt_r != 4'd0);
      cnt_r    <= 4'd0;
    end
  end

  assign level  = level_r;
  assign glitch = glitch_r;

endmodule

// File: rtl/gb_bus_frontend.sv
// Cartridge-edge frontend: synchronises and de-glitches the Game Boy bus and
// turns it into clean bus events for the mapper.
// Ports:
//   clk  - FPGA clock
//   rst  - asynchronous active-low reset
//   bus  - gb_bus_frontend_if.slave (raw gb_* in; bus_addr, bus_wdata,
//          wr_pulse, rom_rd, ram_rd, bus_err, glitch_cnt out)
module gb_bus_frontend #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int GLITCH_CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  gb_bus_frontend_if.slave    bus
);
  import gb_bus_pkg::*;

  localparam logic [4:0]              SETTLE     = 5'(SYNC_STAGES + FILTER_CYCLES);
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_MAX = {GLITCH_CNT_W{1'b1}};

  logic wr_lvl_s, rd_lvl_s, cs_lvl_s;
  logic wr_gl_s, rd_gl_s, cs_gl_s;
  logic wr_act_s, rd_act_s, cs_act_s;

  logic [23:0]             bus_sync_r [SYNC_STAGES];
  logic [23:0]             bus_last_s;
  logic [4:0]              settle_r;
  logic                    arm_r;
  bus_state_t              state_r, state_next;
  logic [15:0]             bus_addr_r;
  logic [7:0]              bus_wdata_r;
  logic                    wr_pulse_r;
  logic                    bus_err_r;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_r;

  gb_strobe_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_wr_flt (
    .clk(clk), .rst(rst), .raw(bus.gb_wr), .level(wr_lvl_s), .glitch(wr_gl_s));
  gb_strobe_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_rd_flt (
    .clk(clk), .rst(rst), .raw(bus.gb_rd), .level(rd_lvl_s), .glitch(rd_gl_s));
  gb_strobe_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_cs_flt (
    .clk(clk), .rst(rst), .raw(bus.gb_cs), .level(cs_lvl_s), .glitch(cs_gl_s));

  assign wr_act_s = ~wr_lvl_s;
  assign rd_act_s = ~rd_lvl_s;
  assign cs_act_s = ~cs_lvl_s;

  // Address/data synchroniser, preset all-ones like the strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        bus_sync_r[i] <= {24{1'b1}};
      end
    end else begin
      bus_sync_r[0] <= {bus.gb_addr, bus.gb_data};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        bus_sync_r[i] <= bus_sync_r[i-1];
      end
    end
  end

  assign bus_last_s = bus_sync_r[SYNC_STAGES-1];

  // After reset, accept new cycles only once the pipeline has flushed and both
  // strobes are seen idle, so a write that was in flight at reset is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_r <= 5'd0;
      arm_r    <= 1'b0;
    end else begin
      if (settle_r != SETTLE) begin
        settle_r <= settle_r + 5'd1;
      end else begin
        settle_r <= settle_r;
      end
      arm_r <= arm_r | ((settle_r == SETTLE) & ~wr_act_s & ~rd_act_s);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // FSM next-state logic; conflicting strobes always win over completion.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (!arm_r)                    state_next = IDLE;
        else if (wr_act_s && rd_act_s) state_next = ERR;
        else if (rd_act_s)             state_next = RD;
        else if (wr_act_s)             state_next = WR;
        else                           state_next = IDLE;
      end
      RD: begin
        if (wr_act_s)       state_next = ERR;
        else if (!rd_act_s) state_next = IDLE;
        else                state_next = RD;
      end
      WR: begin
        if (rd_act_s)       state_next = ERR;
        else if (!wr_act_s) state_next = COMMIT;
        else                state_next = WR;
      end
      COMMIT: state_next = IDLE;
      ERR: begin
        if (!wr_act_s && !rd_act_s) state_next = IDLE;
        else                        state_next = ERR;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered bus outputs: address tracking, write data, event pulses, glitch count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_addr_r   <= 16'h0000;
      bus_wdata_r  <= 8'h00;
      wr_pulse_r   <= 1'b0;
      bus_err_r    <= 1'b0;
      glitch_cnt_r <= {GLITCH_CNT_W{1'b0}};
    end else begin
      if (state_r == IDLE) begin
        bus_addr_r <= bus_last_s[23:8];
      end else begin
        bus_addr_r <= bus_addr_r;
      end
      if (state_r == WR) begin
        bus_wdata_r <= bus_last_s[7:0];
      end else begin
        bus_wdata_r <= bus_wdata_r;
      end
      wr_pulse_r <= (state_next == COMMIT);
      bus_err_r  <= (state_next == ERR) && (state_r != ERR);
      if ((wr_gl_s | rd_gl_s | cs_gl_s) && (glitch_cnt_r != GLITCH_MAX)) begin
        glitch_cnt_r <= glitch_cnt_r + {{(GLITCH_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        glitch_cnt_r <= glitch_cnt_r;
      end
    end
  end

  assign bus.bus_addr   = bus_addr_r;
  assign bus.bus_wdata  = bus_wdata_r;
  assign bus.wr_pulse   = wr_pulse_r;
  assign bus.bus_err    = bus_err_r;
  assign bus.glitch_cnt = glitch_cnt_r;
  // Read qualifiers follow the RD state directly, no extra register stage.
  assign bus.rom_rd     = (state_r == RD) && in_rom(bus_addr_r);
  assign bus.ram_rd     = (state_r == RD) && cs_act_s && in_ram(bus_addr_r);

endmodule
